// File: rtl/npower_memstage.sv
// nPower v1 memory-access stage: byte/word loads and stores (plus update forms)
// on a big-endian Wishbone-style data bus; non-memory results pass straight through.
module npower_memstage #(
  parameter int AWID = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic            x_ld,
  input  logic            x_st,
  input  logic            x_byte,
  input  logic            x_upd,
  input  logic [AWID-1:0] x_ea,
  input  logic [31:0]     x_sdat,
  input  logic [4:0]      x_Rt,
  input  logic [4:0]      x_Ra,
  input  logic            x_wrirf,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4:0]      m_Rt,
  output logic [31:0]     m_res,
  output logic            m_wrirf,
  output logic [4:0]      m_Ra,
  output logic            m_upd,
  output logic [AWID-1:0] m_ea,
  output logic [7:0]      m_cause,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [3:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [31:0]     dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [31:0]     dat_i
);

  typedef enum logic [1:0] {MIDLE, MACK, MOUT, MWACKL} state_t;

  localparam logic [7:0] CAUSE_NONE  = 8'h00;
  localparam logic [7:0] CAUSE_ALIGN = 8'h11;
  localparam logic [7:0] CAUSE_BUS   = 8'h12;

  state_t      state;
  logic        r_ld;
  logic        r_upd;
  logic        r_byte;
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic [31:0] ld_data;

  assign x_ready    = (state == MIDLE) && (!m_valid || m_ready);
  assign accept     = x_valid && x_ready;
  assign is_mem     = x_ld || x_st;
  assign misaligned = !x_byte && (x_ea[1:0] != 2'b00);

  // Big-endian lanes: byte offset 0 lives on bits 31:24.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves ld_data unassigned and infers a latch.
    ld_data = dat_i;
    if (r_byte) begin
      unique case (adr_o[1:0])
        2'd0: ld_data = {24'h0, dat_i[31:24]};
        2'd1: ld_data = {24'h0, dat_i[23:16]};
        2'd2: ld_data = {24'h0, dat_i[15:8]};
        2'd3: ld_data = {24'h0, dat_i[7:0]};
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= MIDLE;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      sel_o   <= 4'h0;
      adr_o   <= '0;
      dat_o   <= 32'h0;
      m_valid <= 1'b0;
      m_wrirf <= 1'b0;
      m_upd   <= 1'b0;
      m_cause <= CAUSE_NONE;
      m_res   <= 32'h0;
      m_Rt    <= 5'd0;
      m_Ra    <= 5'd0;
      m_ea    <= '0;
      r_ld    <= 1'b0;
      r_upd   <= 1'b0;
      r_byte  <= 1'b0;
    end else begin
      unique case (state)
        MIDLE: begin
          if (m_valid && m_ready)
            m_valid <= 1'b0;
          if (accept) begin
            m_Rt <= x_Rt;
            m_Ra <= x_Ra;
            m_ea <= x_ea;
            if (!is_mem) begin
              m_valid <= 1'b1;
              m_res   <= x_ea[31:0];
              m_wrirf <= x_wrirf;
              m_upd   <= 1'b0;
              m_cause <= CAUSE_NONE;
            end else if (misaligned) begin
              m_valid <= 1'b1;
              m_res   <= 32'h0;
              m_wrirf <= 1'b0;
              m_upd   <= 1'b0;
              m_cause <= CAUSE_ALIGN;
            end else begin
              cyc_o  <= 1'b1;
              stb_o  <= 1'b1;
              we_o   <= x_st;
              sel_o  <= x_byte ? (4'b1000 >> x_ea[1:0]) : 4'hF;
              adr_o  <= x_ea;
              dat_o  <= x_byte ? {4{x_sdat[7:0]}} : x_sdat;
              r_ld   <= x_ld;
              r_upd  <= x_upd;
              r_byte <= x_byte;
              state  <= MACK;
            end
          end
        end

        MACK: begin
          if (err_i || ack_i) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            sel_o   <= 4'h0;
            m_valid <= 1'b1;
            m_ea    <= adr_o;
            state   <= MOUT;
            if (err_i) begin
              m_res   <= 32'h0;
              m_wrirf <= 1'b0;
              m_upd   <= 1'b0;
              m_cause <= CAUSE_BUS;
            end else begin
              m_res   <= r_ld ? ld_data : 32'h0;
              m_wrirf <= r_ld;
              m_upd   <= r_upd;
              m_cause <= CAUSE_NONE;
            end
          end
        end

        MOUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ack_i ? MWACKL : MIDLE;
          end
        end

        // Slave still holding ack from the finished cycle; keep the bus quiet.
        MWACKL: begin
          if (!ack_i)
            state <= MIDLE;
        end

        default: state <= MIDLE;
      endcase
    end
  end

endmodule
